// File: rtl/exec_pc_unit.sv
// exec_pc_unit: ALU operand select, ALU with zero/negative flags, and PC register with next-PC selection
// Ports: clk, reset (async, active-high) | halted freezes PC | inst, rs_data, rt_data, alu_operation,
//        alu_src, is_unsigned, does_shift_amount_need, branch, jump, jump_register in |
//        inst_addr (PC), pc_incremented (PC+4), alu_result, zero, negative out
module epc_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module epc_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

module exec_pc_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halted,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [3:0]      alu_operation,
    input  logic            alu_src,
    input  logic            is_unsigned,
    input  logic            does_shift_amount_need,
    input  logic            branch,
    input  logic            jump,
    input  logic            jump_register,
    output logic [XLEN-1:0] inst_addr,
    output logic [XLEN-1:0] pc_incremented,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            negative
);
    logic [XLEN-1:0] pc, next_pc, imm, imm_s, imm_u, shamt, a, b, sum;
    logic [XLEN-1:0] br_off, br_target, j_target, pc_br, pc_j;
    logic            unused_opcode;

    assign unused_opcode = &inst[31:26];
    assign imm_s = {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign imm_u = {{(XLEN-16){1'b0}}, inst[15:0]};
    assign shamt = {{(XLEN-5){1'b0}}, inst[10:6]};

    epc_mux2 #(.W(XLEN)) u_imm (.sel(is_unsigned),            .a(imm_s),   .b(imm_u), .y(imm));
    epc_mux2 #(.W(XLEN)) u_a   (.sel(does_shift_amount_need), .a(rs_data), .b(shamt), .y(a));
    epc_mux2 #(.W(XLEN)) u_b   (.sel(alu_src),                .a(rt_data), .b(imm),   .y(b));
    epc_add32            u_alu_add (.a(a), .b(b), .sum(sum));

    always_comb begin
        alu_result = '0;
        case (alu_operation)
            4'd0:    alu_result = a & b;
            4'd1:    alu_result = a | b;
            4'd2:    alu_result = sum;
            4'd3:    alu_result = a ^ b;
            4'd4:    alu_result = ~(a | b);
            4'd5:    alu_result = b << a[4:0];
            4'd6:    alu_result = a - b;
            4'd7:    alu_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'd8:    alu_result = {{(XLEN-1){1'b0}}, a < b};
            4'd9:    alu_result = b >> a[4:0];
            4'd10:   alu_result = $signed(b) >>> a[4:0];
            4'd11:   alu_result = b << 16;
            4'd12:   alu_result = a * b;
            default: alu_result = '0;
        endcase
    end

    assign zero     = alu_result == '0;
    assign negative = alu_result[XLEN-1];

    // Branch offset is always sign-extended, regardless of is_unsigned.
    assign br_off   = {imm_s[XLEN-3:0], 2'b00};
    assign j_target = {pc_incremented[XLEN-1:XLEN-4], inst[25:0], 2'b00};

    epc_add32 u_pc_inc (.a(pc),             .b(32'd4),  .sum(pc_incremented));
    epc_add32 u_br     (.a(pc_incremented), .b(br_off), .sum(br_target));

    // Chain order gives jump_register > jump > branch > sequential.
    epc_mux2 #(.W(XLEN)) u_sel_br (.sel(branch),        .a(pc_incremented), .b(br_target), .y(pc_br));
    epc_mux2 #(.W(XLEN)) u_sel_j  (.sel(jump),          .a(pc_br),          .b(j_target),  .y(pc_j));
    epc_mux2 #(.W(XLEN)) u_sel_jr (.sel(jump_register), .a(pc_j),           .b(rs_data),   .y(next_pc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else if (!halted)
            pc <= next_pc;
    end

    assign inst_addr = pc;
endmodule

// File: tb/tb_exec_pc_unit.sv
// tb_exec_pc_unit: directed self-checking bench for exec_pc_unit
module tb_exec_pc_unit;
    logic        clk = 0, reset, halted, alu_src, is_unsigned, does_shift_amount_need;
    logic        branch, jump, jump_register;
    logic [31:0] inst, rs_data, rt_data, inst_addr, pc_incremented, alu_result;
    logic [3:0]  alu_operation;
    logic        zero, negative;
    int          n_pass = 0, n_total = 0;

    exec_pc_unit dut (
        .clk(clk), .reset(reset), .halted(halted), .inst(inst),
        .rs_data(rs_data), .rt_data(rt_data), .alu_operation(alu_operation),
        .alu_src(alu_src), .is_unsigned(is_unsigned),
        .does_shift_amount_need(does_shift_amount_need),
        .branch(branch), .jump(jump), .jump_register(jump_register),
        .inst_addr(inst_addr), .pc_incremented(pc_incremented),
        .alu_result(alu_result), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        does_shift_amount_need = 0;
        alu_src = 0;
        alu_operation = op;
        rs_data = a;
        rt_data = b;
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    vec_t vecs[$] = '{
        '{"and",  4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
        '{"or",   4'd1,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34},
        '{"addw", 4'd2,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
        '{"xor",  4'd3,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34},
        '{"nor",  4'd4,  32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000},
        '{"sll",  4'd5,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010},
        '{"slt",  4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{"sltu", 4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{"lui",  4'd11, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000},
        '{"mul",  4'd12, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000},
        '{"mul2", 4'd12, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
        '{"op13", 4'd13, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
        '{"op15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    initial begin
        reset = 1; halted = 0; inst = 0; rs_data = 0; rt_data = 0; alu_operation = 0;
        alu_src = 0; is_unsigned = 0; does_shift_amount_need = 0;
        branch = 0; jump = 0; jump_register = 0;
        #1;
        check("rst_pc", inst_addr, 32'h0);
        check("rst_pcinc", pc_incremented, 32'h4);
        tick(); tick();
        reset = 0;
        tick(); tick(); tick();
        check("seq3", inst_addr, 32'hC);

        alu_operation = 4'd2; rs_data = 5; inst = 32'h0000_FFFF; alu_src = 1; is_unsigned = 0; #1;
        check("imm_signed", alu_result, 32'h4);
        is_unsigned = 1; #1;
        check("imm_unsigned", alu_result, 32'h0001_0004);
        is_unsigned = 0;

        alu(4'd6, 7, 7);
        check("sub_eq", alu_result, 32'h0);
        check("sub_eq_z", {31'b0, zero}, 32'h1);
        alu(4'd6, 3, 5);
        check("sub_neg", alu_result, 32'hFFFF_FFFE);
        check("sub_neg_n", {31'b0, negative}, 32'h1);
        check("sub_neg_z", {31'b0, zero}, 32'h0);

        inst = 32'h0000_0100; rt_data = 32'h8000_0001; rs_data = 32'hFFFF_FFFF;
        does_shift_amount_need = 1; alu_src = 0; alu_operation = 4'd10; #1;
        check("sra", alu_result, 32'hF800_0000);
        alu_operation = 4'd9; #1;
        check("srl", alu_result, 32'h0800_0000);

        foreach (vecs[i]) begin
            alu(vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].tag, alu_result, vecs[i].exp);
        end
        check("op15_z", {31'b0, zero}, 32'h1);

        jump_register = 1; rs_data = 32'h100; tick();
        check("jr100", inst_addr, 32'h100);
        jump_register = 0; branch = 1; inst = 32'h0000_FFFE; tick();
        check("branch_back", inst_addr, 32'hFC);
        branch = 0; jump_register = 1; rs_data = 32'h100; tick();
        jump_register = 0; branch = 1; jump = 1; inst = 32'h0000_0040; tick();
        check("jump_over_br", inst_addr, 32'h100);
        branch = 0; jump = 0; jump_register = 1; rs_data = 32'h4000_0000; tick();
        jump_register = 0; jump = 1; inst = 32'h03FF_FFFF; tick();
        check("jump_upper", inst_addr, 32'h4FFF_FFFC);

        jump_register = 1; jump = 1; branch = 1; rs_data = 32'h2000; tick();
        check("jr_prio", inst_addr, 32'h2000);
        halted = 1; rs_data = 32'h3000; tick(); tick();
        check("halt", inst_addr, 32'h2000);
        halted = 0; jump_register = 0; jump = 0; branch = 0; tick();
        check("resume", inst_addr, 32'h2004);

        branch = 1; inst = 32'h0000_0010;
        reset = 1; #1;
        check("async_rst", inst_addr, 32'h0);
        check("async_rst_inc", pc_incremented, 32'h4);
        tick();
        check("rst_hold", inst_addr, 32'h0);
        reset = 0; branch = 0; tick();
        check("post_rst", inst_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exec_pc_unit.md
# exec_pc_unit

Execute-and-fetch-address block of the single-cycle MIPS-style core. It selects the ALU operands from register data, shift amount or immediate, and computes the ALU result with zero and negative flags. It also holds the program counter and computes the next PC: sequential, branch, jump or jump-register. It sits between the register file and instruction decoder on one side and data/instruction memory on the other.

## Interface
- XLEN, 32, datapath width. Only 32 is required to work.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears PC
- halted  in  1  when 1, PC holds its value
- inst  in  32  current instruction
- rs_data  in  32  register-file rs read value
- rt_data  in  32  register-file rt read value
- alu_operation  in  4  ALU op select
- alu_src  in  1  0: operand B = rt_data; 1: operand B = immediate
- is_unsigned  in  1  0: immediate sign-extended; 1: zero-extended
- does_shift_amount_need  in  1  0: operand A = rs_data; 1: operand A = {27'b0, inst[10:6]}
- branch  in  1  take branch (already qualified by control)
- jump  in  1  J/JAL target
- jump_register  in  1  JR: next PC = rs_data
- inst_addr  out  32  current PC
- pc_incremented  out  32  PC+4, used for JAL link
- alu_result  out  32  ALU output, also the memory address
- zero  out  1  alu_result == 0
- negative  out  1  alu_result[31]

## Operation
- imm = is_unsigned ? {16'b0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]}.
- A = does_shift_amount_need ? shamt : rs_data.
- B = alu_src ? imm : rt_data.
- ALU ops, all modulo 2^32 with no overflow trap:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 XOR
  - 4 NOR
  - 5 SLL: B << A[4:0]
  - 6 SUB: A−B
  - 7 SLT signed: result 1 or 0
  - 8 SLTU: result 1 or 0
  - 9 SRL: B >> A[4:0], logical
  - 10 SRA: B >>> A[4:0], arithmetic
  - 11 LUI: B << 16
  - 12 MUL: low 32 bits of A*B
  - 13–15: result 0
- Shift amount uses only A[4:0]; upper bits are ignored.
- Flags derive from the final alu_result, including for ops 13–15, where zero=1.
- pc_incremented = PC + 4, wrapping at 2^32.
- Branch target = pc_incremented + (sign-extended inst[15:0] << 2). This always uses sign extension, independent of is_unsigned.
- Jump target = {pc_incremented[31:28], inst[25:0], 2'b00}.
- Next-PC priority: jump_register > jump > branch > pc_incremented.
- The implementation is structured from reusable 2:1 mux (parameterised width) and 32-bit adder sub-blocks. Sub-block names are new and must not reuse existing module names.

## Timing
- ALU path, flags, pc_incremented and next-PC logic are purely combinational and valid in the same cycle as their inputs.
- PC is the only state: a 32-bit register updated on the rising clk edge with next-PC when halted=0.
- When halted=1 the PC holds its value.
- Reset asserted: PC = 0 immediately, without waiting for clk. Consequently inst_addr = 0 and pc_incremented = 4 immediately.
- While reset is high, clock edges are ignored.
- First update occurs on the first rising edge after reset deasserts.
- Reset asserted mid-operation overrides any pending branch or jump.
- Simultaneous select signals resolve strictly by the priority above, e.g. jump=1 with branch=1 yields the jump target.
- Latency: a next-PC decision becomes visible on inst_addr one clock edge later.

## Test plan
- Reset: assert reset with no clock edge → inst_addr=0, pc_incremented=4. Release reset, then 3 edges with all selects 0 → inst_addr = 0xC.
- Signed vs unsigned immediate: rs_data=5, inst[15:0]=0xFFFF, alu_src=1, op ADD:
  - is_unsigned=0 → alu_result=4.
  - is_unsigned=1 → 0x00010004.
- Flags: SUB with rs_data=rt_data=7 → result 0, zero=1. SUB 3−5 → 0xFFFFFFFE, negative=1, zero=0.
- Shifts and compares:
  - does_shift_amount_need=1, inst[10:6]=4, rt_data=0x80000001, SRA → 0xF8000000; SRL → 0x08000000.
  - SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- Branch: PC=0x100, branch=1, inst[15:0]=0xFFFE → next PC=0xFC. With jump also 1 and inst[25:0]=0x40 → next PC=0x100.
- Jump-register and halt: jump_register=1, rs_data=0x2000 → next PC=0x2000. With halted=1 across 2 edges → PC unchanged.
